// File: rtl/bats_pitch_pkg.sv
// Shared constants, enums and byte-extraction helpers for the BATS PITCH encoder.
package bats_pitch_pkg;

  localparam logic [15:0] CmdAdd     = 16'd1;
  localparam logic [15:0] CmdExecute = 16'd2;
  localparam logic [15:0] CmdReduce  = 16'd3;
  localparam logic [15:0] CmdDelete  = 16'd4;

  localparam logic [7:0] TypeAdd     = 8'h21;
  localparam logic [7:0] TypeExecute = 8'h23;
  localparam logic [7:0] TypeReduce  = 8'h25;
  localparam logic [7:0] TypeDelete  = 8'h29;

  localparam logic [5:0] HdrLen     = 6'd8;
  localparam logic [5:0] LenAdd     = 6'd34;
  localparam logic [5:0] LenExecute = 6'd26;
  localparam logic [5:0] LenReduce  = 6'd18;
  localparam logic [5:0] LenDelete  = 6'd14;

  typedef enum logic [1:0] {MsgAdd, MsgExecute, MsgReduce, MsgDelete} msg_kind_e;
  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  function automatic logic cmd_is_legal(logic [15:0] cmd);
    return (cmd == CmdAdd) || (cmd == CmdExecute) || (cmd == CmdReduce) || (cmd == CmdDelete);
  endfunction

  function automatic msg_kind_e cmd_to_kind(logic [15:0] cmd);
    msg_kind_e k;
    case (cmd)
      CmdAdd:     k = MsgAdd;
      CmdExecute: k = MsgExecute;
      CmdReduce:  k = MsgReduce;
      default:    k = MsgDelete;
    endcase
    return k;
  endfunction

  function automatic logic [5:0] msg_len(msg_kind_e kind);
    logic [5:0] l;
    case (kind)
      MsgAdd:     l = LenAdd;
      MsgExecute: l = LenExecute;
      MsgReduce:  l = LenReduce;
      default:    l = LenDelete;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] msg_type(msg_kind_e kind);
    logic [7:0] t;
    case (kind)
      MsgAdd:     t = TypeAdd;
      MsgExecute: t = TypeExecute;
      MsgReduce:  t = TypeReduce;
      default:    t = TypeDelete;
    endcase
    return t;
  endfunction

  // Byte k of a little-endian field, k = 0 is the least significant byte.
  function automatic logic [7:0] le_byte64(logic [63:0] v, logic [2:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] le_byte32(logic [31:0] v, logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/bats_pitch_byte_mux.sv
// Combinational byte selector: maps a unit byte index (header + message) to its value
// given the latched command fields and the current sequence / execution ids.
module bats_pitch_byte_mux
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0] UNIT      = 8'd1,
  parameter logic [7:0] ADD_FLAGS = 8'h00
) (
  input  msg_kind_e   kind_i,
  input  logic [5:0]  idx_i,
  input  logic [31:0] seq_i,
  input  logic [63:0] exec_id_i,
  input  logic [31:0] time_i,
  input  logic [63:0] order_id_i,
  input  logic [7:0]  side_i,
  input  logic [31:0] qty_i,
  input  logic [63:0] symbol_i,
  input  logic [63:0] price_i,
  output logic [7:0]  byte_o
);

  logic [5:0] len;
  logic [5:0] b;
  logic [2:0] off;

  always_comb begin
    len    = msg_len(kind_i);
    b      = idx_i - HdrLen;
    off    = '0;
    byte_o = '0;
    if (idx_i < HdrLen) begin
      case (idx_i[2:0])
        3'd0:    byte_o = {2'b00, HdrLen + len};
        3'd1:    byte_o = 8'h00;
        3'd2:    byte_o = 8'd1;
        3'd3:    byte_o = UNIT;
        default: byte_o = le_byte32(seq_i, idx_i[1:0]);
      endcase
    end else if (b == 6'd0) begin
      byte_o = {2'b00, len};
    end else if (b == 6'd1) begin
      byte_o = msg_type(kind_i);
    end else if (b < 6'd6) begin
      byte_o = le_byte32(time_i, b[1:0] - 2'd2);
    end else if (b < 6'd14) begin
      off    = 3'(b - 6'd6);
      byte_o = le_byte64(order_id_i, off);
    end else begin
      case (kind_i)
        MsgAdd: begin
          if (b == 6'd14) begin
            byte_o = side_i;
          end else if (b < 6'd19) begin
            off    = 3'(b - 6'd15);
            byte_o = le_byte32(qty_i, off[1:0]);
          end else if (b < 6'd25) begin
            // Symbol is ASCII in wire order: first character lives in the top byte.
            off    = 3'(b - 6'd19);
            byte_o = le_byte64(symbol_i, 3'd7 - off);
          end else if (b < 6'd33) begin
            off    = 3'(b - 6'd25);
            byte_o = le_byte64(price_i, off);
          end else if (b == 6'd33) begin
            byte_o = ADD_FLAGS;
          end
        end
        MsgExecute: begin
          if (b < 6'd18) begin
            off    = 3'(b - 6'd14);
            byte_o = le_byte32(qty_i, off[1:0]);
          end else if (b < 6'd26) begin
            off    = 3'(b - 6'd18);
            byte_o = le_byte64(exec_id_i, off);
          end
        end
        MsgReduce: begin
          if (b < 6'd18) begin
            off    = 3'(b - 6'd14);
            byte_o = le_byte32(qty_i, off[1:0]);
          end
        end
        default: byte_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/bats_pitch_encoder.sv
// Serializes one order-book command per handshake into a BATS sequenced unit
// (8-byte header + one PITCH message), one byte per accepted clock.
module bats_pitch_encoder
  import bats_pitch_pkg::*;
#(
  parameter logic [7:0]  UNIT      = 8'd1,
  parameter logic [31:0] SEQ_INIT  = 32'd1,
  parameter logic [7:0]  ADD_FLAGS = 8'h00
) (
  input  logic        Clk40Derived2x1I0MHz,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd,
  input  logic [31:0] time_offset,
  input  logic [63:0] order_id,
  input  logic [7:0]  side,
  input  logic [31:0] quantity,
  input  logic [63:0] symbol,
  input  logic [63:0] price,
  input  logic [31:0] executed_quantity,
  input  logic [31:0] cancelled_quantity,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        data_sop,
  output logic        data_eop,
  input  logic        data_ready,
  output logic        cmd_error
);

  state_e      state_q, state_d;
  msg_kind_e   kind_q, kind_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] seq_q, seq_d;
  logic [63:0] exec_id_q, exec_id_d;
  logic [31:0] time_q, time_d;
  logic [63:0] order_id_q, order_id_d;
  logic [7:0]  side_q, side_d;
  logic [31:0] qty_q, qty_d;
  logic [63:0] symbol_q, symbol_d;
  logic [63:0] price_q, price_d;
  logic        cmd_error_q, cmd_error_d;

  logic [7:0]  mux_byte;
  logic [5:0]  last_idx;
  logic        byte_fire;

  assign last_idx  = HdrLen + msg_len(kind_q) - 6'd1;
  assign byte_fire = data_valid & data_ready;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    exec_id_d   = exec_id_q;
    time_d      = time_q;
    order_id_d  = order_id_q;
    side_d      = side_q;
    qty_d       = qty_q;
    symbol_d    = symbol_q;
    price_d     = price_q;
    cmd_error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_is_legal(cmd)) begin
            state_d    = StHdr;
            kind_d     = cmd_to_kind(cmd);
            idx_d      = '0;
            time_d     = time_offset;
            order_id_d = order_id;
            side_d     = side;
            symbol_d   = symbol;
            price_d    = price;
            // Only one quantity field is ever on the wire, so share one register.
            case (cmd)
              CmdExecute: qty_d = executed_quantity;
              CmdReduce:  qty_d = cancelled_quantity;
              default:    qty_d = quantity;
            endcase
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      StHdr: begin
        if (byte_fire) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == HdrLen - 6'd1) state_d = StBody;
        end
      end
      StBody: begin
        if (byte_fire) begin
          if (idx_q == last_idx) begin
            state_d = StIdle;
            idx_d   = '0;
            seq_d   = seq_q + 32'd1;
            if (kind_q == MsgExecute) exec_id_d = exec_id_q + 64'd1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      kind_q      <= MsgDelete;
      idx_q       <= '0;
      seq_q       <= SEQ_INIT;
      exec_id_q   <= 64'd1;
      time_q      <= '0;
      order_id_q  <= '0;
      side_q      <= '0;
      qty_q       <= '0;
      symbol_q    <= '0;
      price_q     <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      exec_id_q   <= exec_id_d;
      time_q      <= time_d;
      order_id_q  <= order_id_d;
      side_q      <= side_d;
      qty_q       <= qty_d;
      symbol_q    <= symbol_d;
      price_q     <= price_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  bats_pitch_byte_mux #(
    .UNIT      (UNIT),
    .ADD_FLAGS (ADD_FLAGS)
  ) u_byte_mux (
    .kind_i     (kind_q),
    .idx_i      (idx_q),
    .seq_i      (seq_q),
    .exec_id_i  (exec_id_q),
    .time_i     (time_q),
    .order_id_i (order_id_q),
    .side_i     (side_q),
    .qty_i      (qty_q),
    .symbol_i   (symbol_q),
    .price_i    (price_q),
    .byte_o     (mux_byte)
  );

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    data_valid = (state_q != StIdle);
    data       = data_valid ? mux_byte : 8'h00;
    data_sop   = data_valid && (idx_q == 6'd0);
    data_eop   = (state_q == StBody) && (idx_q == last_idx);
    cmd_error  = cmd_error_q;
  end

endmodule

// File: tb/tb_bats_pitch_encoder.sv
// Self-checking bench for bats_pitch_encoder: table-driven and random units checked
// against a byte-queue reference model, plus error, sequence-wrap and reset corner cases.
module tb_bats_pitch_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid_a, cmd_valid_w;
  logic [15:0] cmd;
  logic [31:0] time_offset;
  logic [63:0] order_id;
  logic [7:0]  side;
  logic [31:0] quantity;
  logic [63:0] symbol, price;
  logic [31:0] executed_quantity, cancelled_quantity;
  logic        data_ready;

  logic       ready_a, dv_a, sop_a, eop_a, err_a;
  logic [7:0] data_a;
  logic       ready_w, dv_w, sop_w, eop_w, err_w;
  logic [7:0] data_w;

  bats_pitch_encoder dut_a (
    .Clk40Derived2x1I0MHz (clk),
    .reset_n              (rst_n),
    .cmd_valid            (cmd_valid_a),
    .cmd_ready            (ready_a),
    .cmd                  (cmd),
    .time_offset          (time_offset),
    .order_id             (order_id),
    .side                 (side),
    .quantity             (quantity),
    .symbol               (symbol),
    .price                (price),
    .executed_quantity    (executed_quantity),
    .cancelled_quantity   (cancelled_quantity),
    .data_valid           (dv_a),
    .data                 (data_a),
    .data_sop             (sop_a),
    .data_eop             (eop_a),
    .data_ready           (data_ready),
    .cmd_error            (err_a)
  );

  bats_pitch_encoder #(
    .SEQ_INIT (32'hFFFF_FFFF)
  ) dut_w (
    .Clk40Derived2x1I0MHz (clk),
    .reset_n              (rst_n),
    .cmd_valid            (cmd_valid_w),
    .cmd_ready            (ready_w),
    .cmd                  (cmd),
    .time_offset          (time_offset),
    .order_id             (order_id),
    .side                 (side),
    .quantity             (quantity),
    .symbol               (symbol),
    .price                (price),
    .executed_quantity    (executed_quantity),
    .cancelled_quantity   (cancelled_quantity),
    .data_valid           (dv_w),
    .data                 (data_w),
    .data_sop             (sop_w),
    .data_eop             (eop_w),
    .data_ready           (data_ready),
    .cmd_error            (err_w)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [31:0] tofs;
    logic [63:0] oid;
    logic [7:0]  side;
    logic [31:0] qty;
    logic [63:0] sym;
    logic [63:0] price;
    logic [31:0] exq;
    logic [31:0] cxq;
    int          exp_len;
    logic [7:0]  exp_type;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_seq[2];
  logic [63:0] m_exec[2];
  logic [7:0]  exp_q[$];
  logic [7:0]  body[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_le(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) body.push_back(8'(v >> (8 * i)));
  endtask

  // Reference unit: message body from field rules, then header wrapped around it.
  task automatic build(input vec_t v, input int w);
    logic [7:0] typ;
    int mlen;
    body = {};
    typ  = 8'h00;
    case (v.cmd)
      16'd1: begin
        typ = 8'h21;
        push_le(64'(v.tofs), 4); push_le(v.oid, 8); push_le(64'(v.side), 1);
        push_le(64'(v.qty), 4);
        for (int i = 0; i < 6; i++) body.push_back(8'(v.sym >> (56 - 8 * i)));
        push_le(v.price, 8); push_le(64'h0, 1);
      end
      16'd2: begin
        typ = 8'h23;
        push_le(64'(v.tofs), 4); push_le(v.oid, 8); push_le(64'(v.exq), 4); push_le(m_exec[w], 8);
      end
      16'd3: begin
        typ = 8'h25;
        push_le(64'(v.tofs), 4); push_le(v.oid, 8); push_le(64'(v.cxq), 4);
      end
      default: begin
        typ = 8'h29;
        push_le(64'(v.tofs), 4); push_le(v.oid, 8);
      end
    endcase
    mlen  = body.size() + 2;
    exp_q = {};
    exp_q.push_back(8'(8 + mlen));
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(m_seq[w] >> (8 * i)));
    exp_q.push_back(8'(mlen));
    exp_q.push_back(typ);
    foreach (body[i]) exp_q.push_back(body[i]);
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input vec_t v, input int w);
    int tries = 0;
    logic rdy;
    cmd = v.cmd; time_offset = v.tofs; order_id = v.oid; side = v.side; quantity = v.qty;
    symbol = v.sym; price = v.price; executed_quantity = v.exq; cancelled_quantity = v.cxq;
    if (w == 0) cmd_valid_a = 1'b1; else cmd_valid_w = 1'b1;
    rdy = (w == 0) ? ready_a : ready_w;
    while (!rdy && tries < 100) begin
      @(negedge clk);
      tries++;
      rdy = (w == 0) ? ready_a : ready_w;
    end
    if (!rdy) chk("cmd_ready_timeout", 64'(rdy), 64'd1);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_w = 1'b0;
    // Scramble inputs: the unit must come only from latched fields.
    time_offset = $urandom; order_id = {$urandom, $urandom}; side = 8'($urandom);
    quantity = $urandom; executed_quantity = $urandom; cancelled_quantity = $urandom;
    symbol = {$urandom, $urandom}; price = {$urandom, $urandom}; cmd = 16'($urandom);
    chk("cmd_ready_busy", 64'((w == 0) ? ready_a : ready_w), 64'd0);
  endtask

  task automatic run_unit(input vec_t v, input int w, input bit rnd);
    int n = 0, cyc = 0;
    bit done = 0, stall = 0;
    logic [7:0] held = 8'h00, dd;
    logic dv, sp, ep;
    build(v, w);
    issue(v, w);
    while (!done && cyc < 2000) begin
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dv = (w == 0) ? dv_a : dv_w;
      dd = (w == 0) ? data_a : data_w;
      sp = (w == 0) ? sop_a : sop_w;
      ep = (w == 0) ? eop_a : eop_w;
      if (stall) begin
        chk("hold_valid", 64'(dv), 64'd1);
        chk("hold_data", 64'(dd), 64'(held));
      end
      if (dv && data_ready) begin
        if (n >= exp_q.size()) begin
          chk("extra_byte", 64'(n), 64'(exp_q.size()));
          done = 1;
        end else begin
          chk($sformatf("byte[%0d]", n), 64'(dd), 64'(exp_q[n]));
          chk("sop", 64'(sp), 64'(n == 0));
          chk("eop", 64'(ep), 64'(n == exp_q.size() - 1));
          if (n == 9) chk("msg_type", 64'(dd), 64'(v.exp_type));
          if (ep) done = 1;
        end
        n++;
      end
      stall = dv && !data_ready;
      held  = dd;
      @(negedge clk);
      cyc++;
    end
    data_ready = 1'b1;
    chk("unit_len", 64'(n), 64'(v.exp_len));
    chk("idle_gap_valid", 64'((w == 0) ? dv_a : dv_w), 64'd0);
    chk("idle_gap_ready", 64'((w == 0) ? ready_a : ready_w), 64'd1);
    m_seq[w] = m_seq[w] + 32'd1;
    if (v.cmd == 16'd2) m_exec[w] = m_exec[w] + 64'd1;
  endtask

  vec_t tbl[5];
  vec_t r;
  int   lens[4] = '{42, 34, 26, 22};
  logic [7:0] types[4] = '{8'h21, 8'h23, 8'h25, 8'h29};

  initial begin
    rst_n = 1'b0; cmd_valid_a = 1'b0; cmd_valid_w = 1'b0; data_ready = 1'b1;
    cmd = '0; time_offset = '0; order_id = '0; side = '0; quantity = '0;
    symbol = '0; price = '0; executed_quantity = '0; cancelled_quantity = '0;
    m_seq[0] = 32'd1; m_seq[1] = 32'hFFFF_FFFF; m_exec[0] = 64'd1; m_exec[1] = 64'd1;

    tbl[0] = '{16'd4, 32'h10, 64'hAB, 8'h00, 32'd0, 64'd0, 64'd0, 32'd0, 32'd0, 22, 8'h29};
    tbl[1] = '{16'd1, 32'h10, 64'hAB, 8'h42, 32'd100, 64'h4141_504C_2020_0000, 64'h2710,
               32'd0, 32'd0, 42, 8'h21};
    tbl[2] = '{16'd2, 32'h20, 64'h55, 8'h00, 32'd0, 64'd0, 64'd0, 32'd7, 32'd0, 34, 8'h23};
    tbl[3] = '{16'd2, 32'h30, 64'h56, 8'h00, 32'd0, 64'd0, 64'd0, 32'd9, 32'd0, 34, 8'h23};
    tbl[4] = '{16'd3, 32'h40, 64'h57, 8'h00, 32'd0, 64'd0, 64'd0, 32'd0, 32'd5, 26, 8'h25};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(ready_a), 64'd1);
    chk("rst_data_valid", 64'(dv_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_sop", 64'(sop_a), 64'd0);
    chk("rst_eop", 64'(eop_a), 64'd0);
    chk("rst_cmd_error", 64'(err_a), 64'd0);

    for (int i = 0; i < 5; i++) run_unit(tbl[i], 0, i[0]);

    // Illegal command: one error pulse, no data, sequence untouched.
    cmd = 16'd7; cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    chk("err_pulse", 64'(err_a), 64'd1);
    chk("err_no_data", 64'(dv_a), 64'd0);
    @(negedge clk);
    chk("err_one_cycle", 64'(err_a), 64'd0);
    chk("err_still_idle", 64'(dv_a), 64'd0);
    run_unit(tbl[0], 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int k;
      k = $urandom_range(0, 3);
      r = '{16'(k + 1), $urandom, {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? 8'h42 : 8'h53,
            $urandom, {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
            lens[k], types[k]};
      run_unit(r, 0, 1'b1);
    end

    // Sequence wrap on the second instance.
    run_unit(tbl[0], 1, 1'b0);
    run_unit(tbl[0], 1, 1'b1);

    // Reset while mid-unit: output truncated at once, counters restart.
    build(tbl[0], 0);
    issue(tbl[0], 0);
    data_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_valid", 64'(dv_a), 64'd1);
    chk("pre_reset_byte5", 64'(data_a), 64'(exp_q[5]));
    rst_n = 1'b0;
    #1;
    chk("trunc_valid", 64'(dv_a), 64'd0);
    chk("trunc_data", 64'(data_a), 64'd0);
    chk("trunc_eop", 64'(eop_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_seq[0] = 32'd1; m_seq[1] = 32'hFFFF_FFFF; m_exec[0] = 64'd1; m_exec[1] = 64'd1;
    @(negedge clk);
    run_unit(tbl[0], 0, 1'b0);
    run_unit(tbl[2], 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
